mem_arb: RTL

- Scheduler for the single byte-serial RAM port. Shares it between instruction fetch and the load/store buffer (LSB).
- Serialises 1/2/4-byte reads and writes into byte beats. Assembles little-endian words and returns them with a one-cycle done pulse.
- Enforces write > load > fetch priority, with an anti-starvation override for fetch.
- Handles pipeline flush and stalls IO writes while the IO buffer is full. Sits between the fetch unit / LSB and the top-level RAM/IO bus.

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg - shared encodings for the byte-serial RAM port scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  localparam int IO_FIELD_HI = 17;
  localparam int IO_FIELD_LO = 16;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  localparam int GNT_IF = 0;
  localparam int GNT_LD = 1;
  localparam int GNT_ST = 2;

  typedef logic [2:0] grant_t;

  // Unsupported length codes fall back to a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_BYTE: return LEN_BYTE;
      LEN_HALF: return LEN_HALF;
      default:  return LEN_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pick - fixed-priority one-hot grant with fetch starvation override
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   ls_we,
  input  logic   io_blocked,
  input  logic   starved,
  output grant_t grant
);

  always_comb begin
    grant = '0;
    if (if_req && starved) begin
      grant[GNT_IF] = 1'b1;
    end else if (ls_req && ls_we && !io_blocked) begin
      grant[GNT_ST] = 1'b1;
    end else if (ls_req && !ls_we) begin
      grant[GNT_LD] = 1'b1;
    end else if (if_req) begin
      grant[GNT_IF] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb - shares the byte-serial RAM port between fetch and the LSB
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_LIMIT = 8,
  parameter logic [1:0] IO_SEL       = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          len_q, len_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  req_id_e             who_q, who_d;
  logic [31:0]         buf_q, buf_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [31:0]         mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;

  logic        io_blocked;
  logic        starved;
  grant_t      grant;
  logic [31:0] beat_addr;
  logic [1:0]  byte_idx;
  logic [31:0] captured;

  assign io_blocked = ls_we && (ls_addr[IO_FIELD_HI:IO_FIELD_LO] == IO_SEL) && io_buffer_full;
  assign starved    = (starve_q >= STARVE_W'(STARVE_LIMIT));

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .io_blocked (io_blocked),
    .starved    (starved),
    .grant      (grant)
  );

  // cnt_q counts edges since the grant: beat k issues at k, byte k lands at k+2.
  assign beat_addr = addr_q + 32'(cnt_q);
  assign byte_idx  = cnt_q[1:0] - 2'd2;

  always_comb begin
    captured = buf_q;
    captured[{byte_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    who_d      = who_q;
    buf_d      = buf_q;
    starve_d   = starve_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!flush && (grant != '0)) begin
          addr_d  = grant[GNT_IF] ? if_addr : ls_addr;
          len_d   = grant[GNT_IF] ? LEN_WORD : norm_len(ls_len);
          who_d   = grant[GNT_IF] ? REQ_IF : REQ_LS;
          wdata_d = ls_wdata;
          buf_d   = '0;
          cnt_d   = 3'd1;
          mem_a_d = grant[GNT_IF] ? if_addr : ls_addr;
          if (grant[GNT_ST]) begin
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            state_d    = ST_READ;
          end
        end
        if (grant[GNT_IF] && !flush) begin
          starve_d = '0;
        end else if (if_req && !starved) begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end

      ST_READ: begin
        if (flush) begin
          mem_wr_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < len_q) begin
            mem_a_d = beat_addr;
          end
          if (cnt_q >= 3'd2) begin
            buf_d = captured;
          end
          if (cnt_q == len_q + 3'd1) begin
            state_d = ST_DONE;
            if (who_q == REQ_IF) begin
              if_data_d = captured;
              if_done_d = 1'b1;
            end else begin
              ls_rdata_d = captured;
              ls_done_d  = 1'b1;
            end
          end
        end
      end

      // Stores are already committed, so a flush does not interrupt them.
      ST_WRITE: begin
        if (cnt_q < len_q) begin
          mem_a_d    = beat_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          mem_wr_d  = 1'b0;
          ls_done_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      who_q      <= REQ_IF;
      buf_q      <= '0;
      starve_q   <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      who_q      <= who_d;
      buf_q      <= buf_d;
      starve_q   <= starve_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule
`default_nettype wire
